// File: rtl/arb_pkg.sv
// Shared definitions for the request/grant arbiter family.
//   arb_state_e : arbiter FSM state (no owner / owner granted)
//   HOLD_W      : width of the per-owner hold counter
package arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  localparam int HOLD_W = 8;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// Searches req[start], req[start+1], ... (modulo NUM_CH) and reports the
// first asserted channel.
//   req        in  NUM_CH  candidate request lines
//   start      in  ID_W    index searched first (must be < NUM_CH)
//   mask_owner in  1       exclude the channel just before start (the
//                          current owner) from the search
//   found      out 1       some eligible request is asserted
//   idx        out ID_W    index of the selected channel (0 when !found)
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   start,
  input  logic              mask_owner,
  output logic              found,
  output logic [ID_W-1:0]   idx
);

  // Channel index examined at search position gi, and whether it is eligible.
  logic [ID_W-1:0]   pos [NUM_CH];
  logic [NUM_CH-1:0] cand;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
      // One extra bit so start+gi cannot overflow before the wrap.
      logic [ID_W:0] sum;
      assign sum     = {1'b0, start} + (ID_W + 1)'(gi);
      assign pos[gi] = (sum >= (ID_W + 1)'(NUM_CH)) ? ID_W'(sum - (ID_W + 1)'(NUM_CH))
                                                     : ID_W'(sum);
      // The owner sits at the last search position; masking it lets the
      // caller ask "is anyone else waiting?".
      if (gi == NUM_CH - 1) begin : g_last
        assign cand[gi] = req[pos[gi]] & ~mask_owner;
      end else begin : g_other
        assign cand[gi] = req[pos[gi]];
      end
    end
  endgenerate

  // Walk from the lowest priority upward so the earliest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (cand[k]) begin
        found = 1'b1;
        idx   = pos[k];
      end
    end
  end

endmodule : rr_pick

// File: rtl/req_gnt_arbiter.sv
// N-channel round-robin request/grant arbiter with optional hold limit.
// An owner keeps the grant while it requests; if MAX_HOLD is non-zero and
// another channel waits, ownership rotates after MAX_HOLD cycles.
//   clk       in  1       clock, rising edge
//   reset     in  1       asynchronous active-high reset
//   req       in  NUM_CH  level-sensitive request per channel
//   gnt       out NUM_CH  registered one-hot grant, zero when idle
//   gnt_valid out 1       registered OR of gnt
//   gnt_id    out ID_W    index of granted channel, holds while idle
module req_gnt_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int MAX_HOLD = 0,
  localparam int ID_W     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt,
  output logic              gnt_valid,
  output logic [ID_W-1:0]   gnt_id
);

  // Counter ceiling: the forced-rotation point, or free-running saturation
  // when the hold limit is disabled.
  localparam logic [HOLD_W-1:0] HOLD_LIM = (MAX_HOLD == 0) ? HOLD_W'(255)
                                                           : HOLD_W'(MAX_HOLD - 1);
  localparam logic              HOLD_EN  = (MAX_HOLD != 0);
  localparam logic [ID_W-1:0]   LAST_CH  = ID_W'(NUM_CH - 1);

  arb_state_e        state_reg;
  logic [ID_W-1:0]   last_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;

  logic [ID_W-1:0]   search_start;
  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic              owner_req;
  logic              take_winner;
  logic              go_idle;

  // In GRANT, last_reg is the owner, so starting at last+1 serves both the
  // idle search and the "next after owner" search.
  assign search_start = (last_reg == LAST_CH) ? '0 : last_reg + 1'b1;
  assign owner_req    = req[last_reg];

  rr_pick #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_pick (
    .req        (req),
    .start      (search_start),
    .mask_owner (state_reg == ARB_GRANT),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  always_comb begin
    take_winner = 1'b0;
    go_idle     = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        take_winner = pick_found;
      end
      ARB_GRANT: begin
        if (!owner_req) begin
          take_winner = pick_found;
          go_idle     = !pick_found;
        end else begin
          // With the owner masked, pick_found means someone else is waiting.
          take_winner = HOLD_EN && (hold_cnt_reg == HOLD_LIM) && pick_found;
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ARB_IDLE;
      last_reg     <= LAST_CH;
      hold_cnt_reg <= '0;
      gnt          <= '0;
      gnt_valid    <= 1'b0;
      gnt_id       <= '0;
    end else if (take_winner) begin
      state_reg    <= ARB_GRANT;
      last_reg     <= pick_idx;
      hold_cnt_reg <= '0;
      gnt          <= NUM_CH'(1) << pick_idx;
      gnt_valid    <= 1'b1;
      gnt_id       <= pick_idx;
    end else if (go_idle) begin
      state_reg    <= ARB_IDLE;
      hold_cnt_reg <= '0;
      gnt          <= '0;
      gnt_valid    <= 1'b0;
    end else if (state_reg == ARB_GRANT && hold_cnt_reg != HOLD_LIM) begin
      hold_cnt_reg <= hold_cnt_reg + 1'b1;
    end
  end

endmodule : req_gnt_arbiter

// File: tb/tb_req_gnt_arbiter.sv
// Directed and random checks for req_gnt_arbiter. Instance a uses the
// unlimited hold setting, instance b uses MAX_HOLD = 3.
module tb_req_gnt_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req_a, req_b;
  logic [N-1:0] gnt_a, gnt_b;
  logic         valid_a, valid_b;
  logic [1:0]   id_a, id_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  req_gnt_arbiter #(.NUM_CH(N), .MAX_HOLD(0)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .req       (req_a),
    .gnt       (gnt_a),
    .gnt_valid (valid_a),
    .gnt_id    (id_a)
  );

  req_gnt_arbiter #(.NUM_CH(N), .MAX_HOLD(3)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .req       (req_b),
    .gnt       (gnt_b),
    .gnt_valid (valid_b),
    .gnt_id    (id_b)
  );

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_a = '0;
    req_b = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_a = '0;
    req_b = '0;
    step();
    step();
    vectors++;
    if ({gnt_a, valid_a, id_a} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_a: got gnt=%b valid=%b id=%0d, want gnt=0000 valid=0 id=0", gnt_a, valid_a, id_a);
    end
    vectors++;
    if ({gnt_b, valid_b, id_b} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_b: got gnt=%b valid=%b id=%0d, want gnt=0000 valid=0 id=0", gnt_b, valid_b, id_b);
    end
    reset = 1'b0;
  endtask

  // All channels requesting after reset: channel 0 wins and keeps it.
  task automatic test_priority();
    req_a = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (gnt_a !== 4'b0001 || id_a !== 2'd0 || valid_a !== 1'b1) begin
        miscompares++;
        $display("FAIL priority cyc%0d: got gnt=%b id=%0d valid=%b, want gnt=0001 id=0 valid=1", i, gnt_a, id_a, valid_a);
      end
    end
  endtask

  // Owner drops its request: grant moves to the next channel with no gap.
  task automatic test_rotate();
    logic [N-1:0] rq  [4];
    logic [N-1:0] exp [4];
    logic [1:0]   eid [4];
    rq[0] = 4'b1110; exp[0] = 4'b0010; eid[0] = 2'd1;
    rq[1] = 4'b1101; exp[1] = 4'b0100; eid[1] = 2'd2;
    rq[2] = 4'b1011; exp[2] = 4'b1000; eid[2] = 2'd3;
    rq[3] = 4'b0111; exp[3] = 4'b0001; eid[3] = 2'd0;
    for (int i = 0; i < 4; i++) begin
      req_a = rq[i];
      step();
      vectors++;
      if (gnt_a !== exp[i] || id_a !== eid[i]) begin
        miscompares++;
        $display("FAIL rotate step%0d: got gnt=%b id=%0d, want gnt=%b id=%0d", i, gnt_a, id_a, exp[i], eid[i]);
      end
    end
  endtask

  // Release to idle keeps gnt_id; next idle search resumes after last owner.
  task automatic test_idle();
    req_a = 4'b0100;
    step();
    vectors++;
    if (gnt_a !== 4'b0100 || id_a !== 2'd2) begin
      miscompares++;
      $display("FAIL idle_pre: got gnt=%b id=%0d, want gnt=0100 id=2", gnt_a, id_a);
    end
    req_a = 4'b0000;
    step();
    vectors++;
    if (gnt_a !== 4'b0000 || valid_a !== 1'b0 || id_a !== 2'd2) begin
      miscompares++;
      $display("FAIL idle: got gnt=%b valid=%b id=%0d, want gnt=0000 valid=0 id=2", gnt_a, valid_a, id_a);
    end
    req_a = 4'b0011;
    step();
    vectors++;
    if (gnt_a !== 4'b0001 || valid_a !== 1'b1 || id_a !== 2'd0) begin
      miscompares++;
      $display("FAIL idle_regrant: got gnt=%b valid=%b id=%0d, want gnt=0001 valid=1 id=0", gnt_a, valid_a, id_a);
    end
  endtask

  // Hold limit 3 with two constant requesters: 3 cycles each, alternating.
  task automatic test_max_hold();
    logic [N-1:0] exp [9];
    apply_reset();
    for (int i = 0; i < 9; i++) exp[i] = 4'b0001;
    exp[3] = 4'b0010; exp[4] = 4'b0010; exp[5] = 4'b0010;
    req_a = 4'b0011;
    req_b = 4'b0011;
    for (int i = 0; i < 9; i++) begin
      step();
      vectors++;
      if (gnt_b !== exp[i]) begin
        miscompares++;
        $display("FAIL max_hold cyc%0d: got gnt=%b, want %b", i, gnt_b, exp[i]);
      end
    end
    vectors++;
    if (gnt_a !== 4'b0001) begin
      miscompares++;
      $display("FAIL no_limit_hold: got gnt=%b, want 0001", gnt_a);
    end
  endtask

  // Saturated hold count with a lone requester, then rotation on first contender.
  task automatic test_hold_saturate();
    apply_reset();
    req_a = 4'b0100;
    req_b = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (gnt_b !== 4'b0100) begin
        miscompares++;
        $display("FAIL hold_sat cyc%0d: got gnt=%b, want 0100", i, gnt_b);
      end
    end
    req_a = 4'b0101;
    req_b = 4'b0101;
    step();
    vectors++;
    if (gnt_b !== 4'b0001 || id_b !== 2'd0) begin
      miscompares++;
      $display("FAIL hold_sat_rotate: got gnt=%b id=%0d, want gnt=0001 id=0", gnt_b, id_b);
    end
    vectors++;
    if (gnt_a !== 4'b0100) begin
      miscompares++;
      $display("FAIL hold_unlimited: got gnt=%b, want 0100", gnt_a);
    end
  endtask

  // Reset mid-cycle clears outputs before the next edge; priority restarts at 0.
  task automatic test_async_reset();
    apply_reset();
    req_a = 4'b0100;
    step();
    vectors++;
    if (gnt_a !== 4'b0100) begin
      miscompares++;
      $display("FAIL async_pre: got gnt=%b, want 0100", gnt_a);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (gnt_a !== 4'b0000 || valid_a !== 1'b0 || id_a !== 2'd0) begin
      miscompares++;
      $display("FAIL async_clear: got gnt=%b valid=%b id=%0d, want gnt=0000 valid=0 id=0", gnt_a, valid_a, id_a);
    end
    req_a = 4'b0110;
    step();
    reset = 1'b0;
    step();
    vectors++;
    if (gnt_a !== 4'b0010 || id_a !== 2'd1) begin
      miscompares++;
      $display("FAIL async_restart: got gnt=%b id=%0d, want gnt=0010 id=1", gnt_a, id_a);
    end
  endtask

  // Slowly-varying random requests: grant stays one-hot/zero and any
  // continuously requesting channel is served within N grant changes.
  task automatic test_random();
    int           wait_a [N];
    int           wait_b [N];
    logic [N-1:0] prev_a, prev_b, used_a, used_b;
    apply_reset();
    prev_a = '0;
    prev_b = '0;
    for (int c = 0; c < N; c++) begin
      wait_a[c] = 0;
      wait_b[c] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(7) == 0) req_a[c] = ~req_a[c];
        if ($urandom_range(7) == 0) req_b[c] = ~req_b[c];
      end
      used_a = req_a;
      used_b = req_b;
      step();
      vectors++;
      if (!$onehot0(gnt_a) || valid_a !== (|gnt_a)) begin
        miscompares++;
        $display("FAIL onehot_a cyc%0d: got gnt=%b valid=%b, want one-hot/zero with matching valid", cyc, gnt_a, valid_a);
      end
      vectors++;
      if (!$onehot0(gnt_b) || valid_b !== (|gnt_b)) begin
        miscompares++;
        $display("FAIL onehot_b cyc%0d: got gnt=%b valid=%b, want one-hot/zero with matching valid", cyc, gnt_b, valid_b);
      end
      for (int c = 0; c < N; c++) begin
        if (!used_a[c] || gnt_a[c]) wait_a[c] = 0;
        else if (gnt_a != prev_a && gnt_a != '0) wait_a[c]++;
        if (!used_b[c] || gnt_b[c]) wait_b[c] = 0;
        else if (gnt_b != prev_b && gnt_b != '0) wait_b[c]++;
        vectors++;
        if (wait_a[c] > N || wait_b[c] > N) begin
          miscompares++;
          $display("FAIL starve ch%0d cyc%0d: got waits a=%0d b=%0d grant changes, want <= %0d", c, cyc, wait_a[c], wait_b[c], N);
          wait_a[c] = 0;
          wait_b[c] = 0;
        end
      end
      prev_a = gnt_a;
      prev_b = gnt_b;
    end
  endtask

  initial begin
    reset = 1'b1;
    req_a = '0;
    req_b = '0;
    test_reset();
    test_priority();
    test_rotate();
    test_idle();
    test_max_hold();
    test_hold_saturate();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_req_gnt_arbiter

// File: doc/req_gnt_arbiter.md
# req_gnt_arbiter

Parametrised N-channel request/grant arbiter, the multi-requester successor to the single-channel registered req→gnt stage. Each cycle it samples up to `NUM_CH` request lines and drives a registered one-hot grant using round-robin priority. A granted requester keeps the grant until it drops its request, or until an optional maximum-hold limit forces rotation to a waiting channel. It sits between bus masters and a shared resource, such as a memory port or bus.

## Interface
- `NUM_CH`, default 4: number of requesting channels, 2..32.
- `MAX_HOLD`, default 0: max consecutive grant cycles per owner while others wait; 0 = unlimited, range 0..255.
- `ID_W`, derived: `$clog2(NUM_CH)`, width of `gnt_id`.
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_CH  request per channel, level-sensitive.
- `gnt`  out  NUM_CH  registered one-hot grant; all-zero when idle.
- `gnt_valid`  out  1  OR of `gnt`, registered.
- `gnt_id`  out  ID_W  index of the granted channel; holds its last value while idle.

## Operation
- States: IDLE (no owner) and GRANT (owner `o`).
- Round-robin pointer `last` holds the index of the most recent owner.
- Search order for the winner: `last+1, last+2, …` modulo `NUM_CH`.
- IDLE, `req` all-zero: stay in IDLE.
- IDLE, `req` non-zero: grant the winner; go to GRANT; `hold_cnt`=0; `last`=winner.
- GRANT, `req[o]`=0, other requests pending: switch directly to the winner from `o+1`, with no idle bubble; `hold_cnt`=0.
- GRANT, `req[o]`=0, no requests: go to IDLE; `gnt`=0.
- GRANT, `req[o]`=1, `MAX_HOLD`≠0, `hold_cnt`==`MAX_HOLD-1`, another request pending: force rotation to the winner from `o+1`.
- GRANT, `req[o]`=1, otherwise: keep `o`. `hold_cnt` increments and saturates at `MAX_HOLD-1`, or at 255 when `MAX_HOLD`=0.
- Hold-limit saturation with no other requester: the owner keeps the grant indefinitely. Rotation fires on the first cycle another request appears.
- A channel whose request is withdrawn before it is granted is skipped, with no memory of it.
- `gnt` is one-hot or zero at all times; two bits set is a bug.

## Timing
- Reset (async assert, sync release): `gnt`=0, `gnt_valid`=0, `gnt_id`=0, state=IDLE, `hold_cnt`=0, `last`=`NUM_CH-1`. Channel 0 therefore has highest priority on the first grant after reset.
- Grant latency: a request sampled at edge k produces `gnt` visible after edge k, i.e. one cycle, matching the previous single-channel stage.
- Release latency: the owner's `req` seen low at edge k means `gnt` changes after edge k; the next owner can be granted in that same cycle.
- Forced rotation: the owner holds `gnt` for exactly `MAX_HOLD` consecutive cycles before the switch.
- Reset asserted mid-grant: outputs clear immediately, without waiting for a clock edge. After release, arbitration restarts from channel 0 priority.
- Outputs depend only on registered state; there is no combinational path from `req` to `gnt`.

## Structure
- Package `arb_pkg`: state enum `arb_state_e` {ARB_IDLE, ARB_GRANT}, and the `HOLD_W`=8 hold-counter width constant.
- Sub-module `rr_pick`: combinational rotating priority picker. Inputs: `req`, `start` index, `mask_owner`. Outputs: `found`, `idx`. Instantiated once, and reusable by future multi-port arbiters.
- Top level contains the FSM, the `last` pointer, `hold_cnt` and the output registers.

## Test plan
Unless stated otherwise, `NUM_CH`=4 and `MAX_HOLD`=0.
- Reset then `req`=4'b1111 held: `gnt`=0001 after the first edge, and it stays 0001 while `req[0]` is high; `gnt_id`=0.
- From that state, drop `req[0]` for one cycle: `gnt`=0010 on the next cycle with no idle gap. Then drop `req[1]`: `gnt`=0100. Then drop `req[2]`: `gnt`=1000. Then drop `req[3]` with `req[0]` high: `gnt` wraps to 0001.
- `MAX_HOLD`=3, `req`=4'b0011 held constant: `gnt` alternates 0001 ×3 cycles, 0010 ×3 cycles, repeating.
- `MAX_HOLD`=3, only `req[2]` high for 10 cycles: `gnt`=0100 for all 10 cycles. Raise `req[0]` at cycle 10: `gnt`=0001 one cycle later.
- Assert `reset` asynchronously mid-cycle while `gnt`=0100: `gnt`, `gnt_valid` and `gnt_id` are 0 before the next edge. Release with `req`=4'b0110: first grant is 0010.
- Random `req` for 10k cycles: `gnt` is always one-hot or zero, and any continuously requesting channel is granted within `NUM_CH` grant changes.
